// File: rtl/data_sram_responder.sv
// data_sram_responder
// Memory-side responder for the data-SRAM handshake. Requests are accepted
// into a small in-order queue, the internal word-addressed RAM is accessed at
// the accept edge, and each entry answers with a one-cycle data_ok strobe once
// its latency counter has run out and it has reached the head of the queue.
//
// Ports
//   clk, resetn        : clock (rising edge) and asynchronous active-low reset
//   data_sram_req      : master request valid
//   data_sram_wr       : 1 = write, 0 = read
//   data_sram_wstrb    : byte-lane write enables (writes only)
//   data_sram_addr     : byte address, word index = addr[ADDR_W+1:2]
//   data_sram_wdata    : write data
//   data_sram_addr_ok  : request accepted when high together with req
//   data_sram_data_ok  : response strobe for the oldest outstanding request
//   data_sram_rdata    : read data, zero unless data_ok is high
//   outstanding        : current queue occupancy
module data_sram_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2,
    parameter int MAX_OUT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    output logic [2:0]  outstanding
);

    localparam logic [3:0] CNT_LOAD  = 4'(LATENCY - 1);
    localparam logic [2:0] MAX_OUT_C = 3'(MAX_OUT);
    localparam logic [1:0] LAST_PTR  = 2'(MAX_OUT - 1);

    // Queue storage is sized for the largest legal MAX_OUT so the 2-bit
    // pointers index it without width games; only MAX_OUT slots are used.
    logic [31:0]       mem_q [2**ADDR_W];
    logic [3:0]        valid_q, valid_d;
    logic [31:0]       data_q [4];
    logic [31:0]       data_d [4];
    logic [3:0]        cnt_q  [4];
    logic [3:0]        cnt_d  [4];
    logic [1:0]        rptr_q, rptr_d;
    logic [1:0]        wptr_q, wptr_d;
    logic [2:0]        occ_q, occ_d;

    logic [ADDR_W-1:0] widx_s;
    logic [31:0]       rd_word_s;
    logic              accept_s;
    logic              pop_s;
    logic              unused_addr_s;

    // Circular pointer advance, wrapping after the last used slot.
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        if (p == LAST_PTR) begin
            return 2'd0;
        end else begin
            return p + 2'd1;
        end
    endfunction

    assign widx_s        = data_sram_addr[ADDR_W+1:2];
    assign unused_addr_s = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};
    assign rd_word_s     = mem_q[widx_s];

    // Admission depends on occupancy only, so a full queue refuses even in
    // the cycle its head pops.
    assign data_sram_addr_ok = (occ_q < MAX_OUT_C);
    assign accept_s          = data_sram_req & data_sram_addr_ok;
    assign pop_s             = valid_q[rptr_q] & (cnt_q[rptr_q] == 4'd0);
    assign data_sram_data_ok = pop_s;
    assign data_sram_rdata   = pop_s ? data_q[rptr_q] : 32'd0;
    assign outstanding       = occ_q;

    // RAM byte-lane writes at the accept edge; contents survive reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (accept_s && data_sram_wr && data_sram_wstrb[i]) begin
                mem_q[widx_s][i*8 +: 8] <= data_sram_wdata[i*8 +: 8];
            end
        end
    end

    // Queue next state: concurrent countdown, head pop, tail push.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        occ_d   = occ_q;

        for (int i = 0; i < 4; i++) begin
            if (valid_q[i] && (cnt_q[i] != 4'd0)) begin
                cnt_d[i] = cnt_q[i] - 4'd1;
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end

        if (pop_s) begin
            valid_d[rptr_q] = 1'b0;
            rptr_d          = ptr_inc(rptr_q);
        end else begin
            rptr_d = rptr_q;
        end

        // The push slot is never the head being popped: a push needs a
        // non-full queue, so the tail slot is free.
        if (accept_s) begin
            valid_d[wptr_q] = 1'b1;
            data_d[wptr_q]  = data_sram_wr ? 32'd0 : rd_word_s;
            cnt_d[wptr_q]   = CNT_LOAD;
            wptr_d          = ptr_inc(wptr_q);
        end else begin
            wptr_d = wptr_q;
        end

        case ({accept_s, pop_s})
            2'b10:   occ_d = occ_q + 3'd1;
            2'b01:   occ_d = occ_q - 3'd1;
            default: occ_d = occ_q;
        endcase
    end

    // Queue state registers; reset drops every outstanding request.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= 4'd0;
            rptr_q  <= 2'd0;
            wptr_q  <= 2'd0;
            occ_q   <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= 32'd0;
                cnt_q[i]  <= 4'd0;
            end
        end else begin
            valid_q <= valid_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            occ_q   <= occ_d;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= data_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
        end
    end

endmodule
